muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning number of iteration cycles; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  mult/div instruction present in EX; held high while the pipeline stalls.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port src_a  input  32  rs operand (multiplicand/dividend).
REQ-007 SHALL have port src_b  input  32  rt operand (multiplier/divisor).
REQ-008 SHALL have port mthi_we  input  1  MTHI write enable.
REQ-009 SHALL have port mtlo_we  input  1  MTLO write enable.
REQ-010 SHALL have port mt_wdata  input  32  MTHI/MTLO data.
REQ-011 SHALL have port ALUStall  output  1  stall request to the hazard unit.
REQ-012 SHALL have port hi  output  32  HI register (MFHI source).
REQ-013 SHALL have port lo  output  32  LO register (MFLO source).

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 IDLE with start=1 (cycle T0) SHALL latch op, operand magnitudes (signed ops) or raw operands (unsigned ops), and the sign flags, clear the iteration counter, and go to CALC.
REQ-016 CALC SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for ITER cycles (T1..T32), then go to FIX.
REQ-017 FIX (T33) SHALL apply sign correction and write hi/lo, then go to DONE.
REQ-018 DONE (T34) SHALL ignore start and return to IDLE next cycle; a start seen in IDLE at T35 begins a new operation (back-to-back).
REQ-019 ALUStall SHALL equal (IDLE & start) | CALC | FIX, combinationally: exactly 34 stall cycles per op, low in DONE.
REQ-020 Multiply: {hi,lo} SHALL be the 64-bit product; signed ops SHALL negate the 64-bit magnitude product when operand signs differ.
REQ-021 Divide: lo SHALL be the quotient and hi the remainder; signed quotient negated when signs differ; remainder takes the dividend's sign.
REQ-022 Divide by zero SHALL give lo=0xFFFFFFFF and hi=src_a (raw, no sign correction).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (32-bit wrap).
REQ-024 mthi_we/mtlo_we SHALL write hi/lo at the clock edge in IDLE or DONE; ignored in CALC/FIX.
REQ-025 If start and an MT write occur in the same IDLE cycle, the MT write SHALL take effect and the op result SHALL later overwrite it in FIX.
REQ-026 hi/lo SHALL hold their value at all times except on an MT write or the FIX write.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counter 0, hi=0, lo=0, and internal operand/accumulator registers to 0.
REQ-028 ALUStall SHALL be 0 during reset unless start=1 (combinational IDLE term).
REQ-029 Reset mid-operation SHALL abort the op with no hi/lo update; the next start begins a fresh op.

Structure
REQ-030 A shared package muldiv_pkg SHALL hold the op encodings, FSM state encoding, and the ITER constant.
REQ-031 One sub-module muldiv_step SHALL implement a single combinational multiply/divide iteration; muldiv_ctrl SHALL hold the FSM, counter, and registers.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> ALUStall high T0..T33; in DONE hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 Back-to-back: MULTU 3x5 then start held for DIVU 100/7 -> DONE at T34 with lo=15; second op accepted at T35; final lo=14, hi=2.
REQ-036 rst_n pulsed low at T10 of MULTU 2x2 (hi/lo preset to 0x11/0x22 via MT writes) -> immediate IDLE, hi=lo=0, ALUStall=0 with start low.
REQ-037 mthi_we with 0xABCD asserted during CALC -> hi unchanged until FIX writes the result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int MD_ITER = 32;   // iteration cycles per operation
   localparam int CNT_W   = 6;    // wide enough to hold 0..MD_ITER

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } md_state_e;

   // Bit 1 of the op selects divide, bit 0 selects unsigned.
   function automatic logic op_is_div(input logic [1:0] o);
      return o[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Multiply: {acc_hi,acc_lo} shifts right, acc_lo holds the unconsumed
// multiplier bits. Divide: acc_hi is the partial remainder, acc_lo shifts
// out dividend bits from the top and takes quotient bits in at the bottom.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic        is_div,
   input  logic [31:0] acc_hi,
   input  logic [31:0] acc_lo,
   input  logic [31:0] opnd,
   output logic [31:0] nxt_hi,
   output logic [31:0] nxt_lo
);

   logic [32:0] sum;
   logic [32:0] shl;
   logic [31:0] diff;

   // Remainder is always below the divisor, so the trial difference fits
   // in 32 bits whenever the subtraction is accepted.
   always_comb begin
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
      shl    = {acc_hi, acc_lo[31]};
      diff   = shl[31:0] - opnd;
      nxt_hi = sum[32:1];
      nxt_lo = {sum[0], acc_lo[31:1]};
      if (is_div) begin
         if (shl >= {1'b0, opnd}) begin
            nxt_hi = diff;
            nxt_lo = {acc_lo[30:0], 1'b1};
         end else begin
            nxt_hi = shl[31:0];
            nxt_lo = {acc_lo[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and stall output.
// Sequence: IDLE(T0 latch) -> CALC(T1..T32) -> FIX(T33 write hi/lo) -> DONE(T34).
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int ITER = MD_ITER
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        mthi_we,
   input  logic        mtlo_we,
   input  logic [31:0] mt_wdata,
   output logic        ALUStall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e        state_q, state_d;
   md_op_e           op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;      // negate product / quotient
   logic             sa_q, sa_d;        // dividend was negative
   logic [31:0]      acc_hi_q, acc_hi_d;
   logic [31:0]      acc_lo_q, acc_lo_d;
   logic [31:0]      opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic [31:0]      step_hi, step_lo;
   logic             a_neg, b_neg;
   logic [31:0]      a_mag, b_mag;
   logic [63:0]      prod;

   muldiv_step u_step (
      .is_div (op_is_div(op_q)),
      .acc_hi (acc_hi_q),
      .acc_lo (acc_lo_q),
      .opnd   (opnd_q),
      .nxt_hi (step_hi),
      .nxt_lo (step_lo)
   );

   // Stall covers the accepting IDLE cycle plus CALC and FIX; DONE releases.
   assign ALUStall = ((state_q == S_IDLE) & start) | (state_q == S_CALC) | (state_q == S_FIX);
   assign hi       = hi_q;
   assign lo       = lo_q;

   // Next-state, datapath and HI/LO update.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      prod     = {acc_hi_q, acc_lo_q};

      a_neg = op_is_signed(op) & src_a[31];
      b_neg = op_is_signed(op) & src_b[31];
      a_mag = a_neg ? -src_a : src_a;
      b_mag = b_neg ? -src_b : src_b;

      case (state_q)
         S_IDLE, S_DONE: begin
            // MT writes land here; an op started this cycle overwrites in FIX.
            if (mthi_we) hi_d = mt_wdata;
            if (mtlo_we) lo_d = mt_wdata;
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end else if (start) begin
               op_d     = md_op_e'(op);
               cnt_d    = '0;
               neg_d    = a_neg ^ b_neg;
               sa_d     = a_neg;
               acc_hi_d = '0;
               acc_lo_d = op_is_div(op) ? a_mag : b_mag;
               opnd_d   = op_is_div(op) ? b_mag : a_mag;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (op_is_div(op_q)) begin
               // Divide by zero leaves quotient all-ones and the dividend
               // magnitude as remainder; restoring its sign gives raw src_a.
               lo_d = (neg_q && opnd_q != 32'd0) ? -acc_lo_q : acc_lo_q;
               hi_d = sa_q ? -acc_hi_q : acc_hi_q;
            end else begin
               if (neg_q) prod = -prod;
               hi_d = prod[63:32];
               lo_d = prod[31:0];
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any op without touching hi/lo later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_MULT;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: stall window, results, MT writes, reset abort.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0, src_b = '0;
   logic        mthi_we = 1'b0, mtlo_we = 1'b0;
   logic [31:0] mt_wdata = '0;
   logic        ALUStall;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_ctrl #(.ITER(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .mthi_we  (mthi_we),
      .mtlo_we  (mtlo_we),
      .mt_wdata (mt_wdata),
      .ALUStall (ALUStall),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge while IDLE. Holds start through T0..T33,
   // checks stall each cycle, checks hi/lo in DONE (T34), optionally keeps
   // start high into T35. mt_at >= 0 pulses MTHI(0xABCD) in that cycle.
   task automatic do_op(input string name, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit keep, input int mt_at);
      logic [31:0] hi_before;
      hi_before = hi;
      start = 1'b1; op = o; src_a = a; src_b = b;
      for (int i = 0; i < 34; i++) begin
         if (i == mt_at) begin
            mthi_we = 1'b1; mt_wdata = 32'h0000ABCD;
         end else if (mt_at >= 0 && i == mt_at + 1) begin
            mthi_we = 1'b0;
            chk({name, " mt_hi"}, hi, (mt_at == 0) ? 32'h0000ABCD : hi_before);
         end
         #1;
         chk($sformatf("%s stall_T%0d", name, i), 32'(ALUStall), 32'd1);
         @(negedge clk);
      end
      #1;
      chk({name, " stall_done"}, 32'(ALUStall), 32'd0);
      chk({name, " hi"}, hi, exp_hi);
      chk({name, " lo"}, lo, exp_lo);
      if (!keep) start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      #12;
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      chk("rst stall", 32'(ALUStall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, -1);
      do_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1);
      do_op("mult_nn",   OP_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0, -1);
      do_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1);
      do_op("divu_z",    OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b0, -1);
      do_op("div_z_neg", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, -1);
      do_op("div_wrap",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, -1);
      do_op("divu_big",  OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, -1);

      // Back-to-back: start stays high through DONE into T35
      do_op("b2b_mul",   OP_MULTU, 32'd3,   32'd5, 32'd0, 32'd15, 1'b1, -1);
      do_op("b2b_div",   OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1);

      // MTHI during CALC is ignored; MTHI with start in IDLE lands, then FIX overwrites
      do_op("mt_calc",   OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6,  1'b0, 5);
      do_op("mt_idle",   OP_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 0);

      // MT writes in IDLE, then reset at T10 of MULTU 2x2
      mthi_we = 1'b1; mt_wdata = 32'h11;
      @(negedge clk);
      mthi_we = 1'b0; mtlo_we = 1'b1; mt_wdata = 32'h22;
      @(negedge clk);
      mtlo_we = 1'b0;
      #1;
      chk("mt hi", hi, 32'h11);
      chk("mt lo", lo, 32'h22);
      start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd2;
      repeat (10) @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      chk("abort stall", 32'(ALUStall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      chk("post_abort hi", hi, 32'd0);
      chk("post_abort lo", lo, 32'd0);
      chk("post_abort stall", 32'(ALUStall), 32'd0);
      @(negedge clk);
      do_op("fresh", OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
